// File: rtl/score_text_reader.sv
// Score text window reader.
// Walks a 4-row by TEXT_COLS-column character window on the display raster,
// fetches character codes from the text RAM and glyph rows from the font ROM,
// and emits one foreground bit per pixel with a fixed 3-Clk latency.
// The text RAM and font ROM each return data in the Clk following the
// address register update, so each lookup consumes exactly one stage.
// A vsync-driven frame counter supplies a slow blink for the whole window.
module score_text_reader #(
   parameter logic [9:0] TEXT_X0   = 10'd0,
   parameter logic [9:0] TEXT_Y0   = 10'd464,
   parameter int         TEXT_COLS = 40
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        vsync,
   input  logic        blink_en,
   output logic [7:0]  read_address,
   input  logic [7:0]  data_Out,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        text_on,
   output logic        text_pixel
);

   // Window bounds held one bit wider so the end column/row cannot wrap.
   localparam logic [10:0] X_BEG = {1'b0, TEXT_X0};
   localparam logic [10:0] Y_BEG = {1'b0, TEXT_Y0};
   localparam logic [10:0] X_END = X_BEG + 11'(8 * TEXT_COLS);
   localparam logic [10:0] Y_END = Y_BEG + 11'd64;

   logic [9:0] dx;
   logic [9:0] dy;
   logic       active;
   logic [7:0] lin_addr;

   // Stage 0 registers
   logic       v0;
   logic [3:0] gr0;
   logic [2:0] bc0;

   // Stage 1 registers
   logic       v1;
   logic [2:0] bc1;
   logic       blank1;

   // Blink state
   logic       vsync_q;
   logic       vsync_fall;
   logic [5:0] frame_cnt;
   logic [5:0] frame_cnt_next;
   logic       hide;

   // Window-relative coordinates, window test and linear character address.
   always_comb begin
      dx       = DrawX - TEXT_X0;
      dy       = DrawY - TEXT_Y0;
      active   = ({1'b0, DrawX} >= X_BEG) && ({1'b0, DrawX} < X_END) &&
                 ({1'b0, DrawY} >= Y_BEG) && ({1'b0, DrawY} < Y_END);
      // Inside the window row <= 3 and col < TEXT_COLS, so 8 bits suffice.
      lin_addr = 8'(dy[9:4]) * 8'(TEXT_COLS) + 8'(dx[9:3]);
   end

   // Stage 0: issue the text RAM address and launch the per-pixel tags.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         read_address <= 8'd0;
         v0           <= 1'b0;
         gr0          <= 4'd0;
         bc0          <= 3'd0;
      end else begin
         read_address <= active ? lin_addr : 8'd0;
         v0           <= active;
         gr0          <= dy[3:0];
         bc0          <= dx[2:0];
      end
   end

   // Stage 1: turn the character code into a font ROM address and blank flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         font_addr <= 11'd0;
         v1        <= 1'b0;
         bc1       <= 3'd0;
         blank1    <= 1'b0;
      end else begin
         font_addr <= {data_Out[6:0], gr0};
         v1        <= v0;
         bc1       <= bc0;
         // NUL and codes with bit 7 set have no glyph and draw nothing.
         blank1    <= (data_Out == 8'h00) || data_Out[7];
      end
   end

   // Stage 2: select the glyph bit and register the pixel outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         text_on    <= 1'b0;
         text_pixel <= 1'b0;
      end else begin
         text_on    <= v1;
         text_pixel <= font_data[3'd7 - bc1] & ~blank1 & v1 & ~hide;
      end
   end

   // Falling edge of the registered vsync marks a new frame.
   always_comb begin
      vsync_fall     = vsync_q & ~vsync;
      frame_cnt_next = frame_cnt + 6'd1;
   end

   // Frame counter and blink flag; hide only changes at a frame boundary.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vsync_q   <= 1'b0;
         frame_cnt <= 6'd0;
         hide      <= 1'b0;
      end else begin
         vsync_q <= vsync;
         if (vsync_fall) begin
            frame_cnt <= frame_cnt_next;
            hide      <= blink_en & frame_cnt_next[5];
         end
      end
   end

endmodule
